// File: rtl/neurotransmitter_channel_bank_pkg.sv
// neurotransmitter_pkg
// Shared definitions for the neurotransmitter channel bank:
//   - state_t       : sweep FSM states (IDLE, CONC, COND, CURR, DONE)
//   - fixed_max/min : largest/smallest value of an n-bit signed fixed-point word
//   - index_width   : bit width of a channel index for a given channel count
// Optional build macro used by the files importing this package:
//   NEUROTRANSMITTER_SATURATE_EN
package neurotransmitter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONC = 3'd1,
        COND = 3'd2,
        CURR = 3'd3,
        DONE = 3'd4
    } state_t;

    // Largest positive two's complement value of an n-bit word (n <= 32).
    function automatic logic signed [63:0] fixed_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    // Most negative two's complement value of an n-bit word (n <= 32).
    function automatic logic signed [63:0] fixed_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    // clog2 of the channel count, never narrower than one bit.
    function automatic int index_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/neurotransmitter_channel_bank_if.sv
// neurotransmitter_channel_bank_if
// Bundles the sweep handshake, the latched operands and the results of the
// channel bank. Per-channel vectors are flat: channel i lives at [i*N +: N].
//   master : drives apply, voltage, threshold, channel_en and the per-channel
//            parameter vectors; observes t, current, total_current, busy, done
//   slave  : the channel bank itself
interface neurotransmitter_channel_bank_if #(
    parameter int N        = 32,
    parameter int CHANNELS = 4
);
    logic                       apply;
    logic signed [N-1:0]        voltage;
    logic signed [N-1:0]        threshold;
    logic [CHANNELS-1:0]        channel_en;
    logic [CHANNELS*N-1:0]      tmax;
    logic [CHANNELS*N-1:0]      clear_constant;
    logic [CHANNELS*N-1:0]      max_synaptic_conductance;
    logic [CHANNELS*N-1:0]      reversal_potential;
    logic [CHANNELS*N-1:0]      t;
    logic [CHANNELS*N-1:0]      current;
    logic signed [N-1:0]        total_current;
    logic                       busy;
    logic                       done;

    modport master (
        output apply, voltage, threshold, channel_en, tmax, clear_constant,
               max_synaptic_conductance, reversal_potential,
        input  t, current, total_current, busy, done
    );

    modport slave (
        input  apply, voltage, threshold, channel_en, tmax, clear_constant,
               max_synaptic_conductance, reversal_potential,
        output t, current, total_current, busy, done
    );
endinterface

// File: rtl/neurotransmitter_channel_bank_fixed_point_mult.sv
// fixed_point_mult
// Combinational signed Q-format multiply: full 2N-bit product, arithmetic
// shift right by Q (rounds toward minus infinity), N-bit result.
//   a, b : signed N-bit operands
//   y    : signed N-bit result; wraps modulo 2^N by default, clamps to the
//          N-bit signed range when NEUROTRANSMITTER_SATURATE_EN is defined
module fixed_point_mult
    import neurotransmitter_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    logic signed [2*N-1:0] product;

    // Operands are sign-extended to 2N bits so the product is exact.
    assign product = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});

`ifdef NEUROTRANSMITTER_SATURATE_EN
    localparam logic signed [63:0]    MAX64 = fixed_max(N);
    localparam logic signed [63:0]    MIN64 = fixed_min(N);
    localparam logic signed [2*N-1:0] HI    = MAX64[2*N-1:0];
    localparam logic signed [2*N-1:0] LO    = MIN64[2*N-1:0];

    logic signed [2*N-1:0] shifted;

    assign shifted = product >>> Q;

    always_comb begin
        y = shifted[N-1:0];
        if (shifted > HI) begin
            y = HI[N-1:0];
        end else if (shifted < LO) begin
            y = LO[N-1:0];
        end
    end
`else
    logic unused_product_bits;

    assign unused_product_bits = ^{product[2*N-1:N+Q], product[Q-1:0]};
    assign y = product[N+Q-1:Q];
`endif

endmodule

// File: rtl/neurotransmitter_channel_bank.sv
// neurotransmitter_channel_bank
// Holds CHANNELS neurotransmitter concentrations. Each apply starts a sweep
// that visits every channel for three cycles (CONC, COND, CURR), sharing one
// fixed_point_mult, then spends one DONE cycle publishing total_current.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : neurotransmitter_channel_bank_if slave (apply/operands in,
//                t/current/total_current/busy/done out)
// Build option: NEUROTRANSMITTER_SATURATE_EN makes the multiply, the
// voltage - E_rev difference, the t decrement and the accumulation saturate
// instead of wrapping.
module neurotransmitter_channel_bank
    import neurotransmitter_pkg::*;
#(
    parameter int N        = 32,
    parameter int Q        = 16,
    parameter int CHANNELS = 4
) (
    input  logic clk,
    input  logic rst_n,
    neurotransmitter_channel_bank_if.slave bus
);

    localparam int            IW   = index_width(CHANNELS);
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

`ifdef NEUROTRANSMITTER_SATURATE_EN
    localparam logic signed [63:0] MAX64  = fixed_max(N);
    localparam logic signed [63:0] MIN64  = fixed_min(N);
    localparam logic signed [N:0]  SUM_HI = MAX64[N:0];
    localparam logic signed [N:0]  SUM_LO = MIN64[N:0];
`endif

    state_t state, state_next;

    logic [IW-1:0]       idx;
    logic signed [N-1:0] voltage_q, threshold_q;
    logic [CHANNELS-1:0] en_q;
    logic signed [N-1:0] tmax_q    [CHANNELS];
    logic signed [N-1:0] clear_q   [CHANNELS];
    logic signed [N-1:0] gmax_q    [CHANNELS];
    logic signed [N-1:0] erev_q    [CHANNELS];
    logic signed [N-1:0] t_reg     [CHANNELS];
    logic signed [N-1:0] current_reg [CHANNELS];
    logic signed [N-1:0] t_new_q, g_q, acc_q, total_q;

    logic                accept;
    logic signed [N-1:0] mul_a, mul_b, mul_y;
    logic signed [N-1:0] diff, t_dec, t_cand, t_clamped, contrib, acc_sum;

    function automatic logic signed [N-1:0] add_fx(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
`ifdef NEUROTRANSMITTER_SATURATE_EN
        logic signed [N:0] s;
        s = {x[N-1], x} + {y[N-1], y};
        if (s > SUM_HI) return SUM_HI[N-1:0];
        if (s < SUM_LO) return SUM_LO[N-1:0];
        return s[N-1:0];
`else
        return x + y;
`endif
    endfunction

    function automatic logic signed [N-1:0] sub_fx(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
`ifdef NEUROTRANSMITTER_SATURATE_EN
        logic signed [N:0] s;
        s = {x[N-1], x} - {y[N-1], y};
        if (s > SUM_HI) return SUM_HI[N-1:0];
        if (s < SUM_LO) return SUM_LO[N-1:0];
        return s[N-1:0];
`else
        return x - y;
`endif
    endfunction

    fixed_point_mult #(.N(N), .Q(Q)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // A new sweep may only begin from IDLE or the DONE cycle; apply is
    // ignored while a sweep is running.
    assign accept = bus.apply && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.apply) state_next = CONC;
            end
            CONC: begin
                bus.busy   = 1'b1;
                state_next = COND;
            end
            COND: begin
                bus.busy   = 1'b1;
                state_next = CURR;
            end
            CURR: begin
                bus.busy   = 1'b1;
                state_next = (idx == LAST) ? DONE : CONC;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = bus.apply ? CONC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The single multiplier serves clearance in CONC, conductance in COND
    // and current in CURR for the channel selected by idx.
    always_comb begin
        diff      = sub_fx(voltage_q, erev_q[idx]);
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            CONC: begin
                mul_a = clear_q[idx];
                mul_b = t_reg[idx];
            end
            COND: begin
                mul_a = gmax_q[idx];
                mul_b = t_new_q;
            end
            CURR: begin
                mul_a = g_q;
                mul_b = diff;
            end
            default: ;
        endcase
        t_dec     = sub_fx(t_reg[idx], mul_y);
        t_cand    = (voltage_q >= threshold_q) ? tmax_q[idx] : t_dec;
        t_clamped = t_cand[N-1] ? '0 : t_cand;
        contrib   = en_q[idx] ? mul_y : '0;
        acc_sum   = add_fx(acc_q, contrib);
    end

    // Operands are captured on accept so mid-sweep input changes are
    // invisible. A disabled channel still runs its three cycles but leaves
    // t untouched and contributes zero current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            voltage_q   <= '0;
            threshold_q <= '0;
            en_q        <= '0;
            t_new_q     <= '0;
            g_q         <= '0;
            acc_q       <= '0;
            total_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                tmax_q[i]      <= '0;
                clear_q[i]     <= '0;
                gmax_q[i]      <= '0;
                erev_q[i]      <= '0;
                t_reg[i]       <= '0;
                current_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                idx         <= '0;
                acc_q       <= '0;
                voltage_q   <= bus.voltage;
                threshold_q <= bus.threshold;
                en_q        <= bus.channel_en;
                for (int i = 0; i < CHANNELS; i++) begin
                    tmax_q[i]  <= bus.tmax[i*N +: N];
                    clear_q[i] <= bus.clear_constant[i*N +: N];
                    gmax_q[i]  <= bus.max_synaptic_conductance[i*N +: N];
                    erev_q[i]  <= bus.reversal_potential[i*N +: N];
                end
            end
            case (state)
                CONC: t_new_q <= t_clamped;
                COND: g_q     <= mul_y;
                CURR: begin
                    if (en_q[idx]) begin
                        t_reg[idx]       <= t_new_q;
                        current_reg[idx] <= mul_y;
                    end else begin
                        current_reg[idx] <= '0;
                    end
                    acc_q <= acc_sum;
                    if (idx == LAST) begin
                        total_q <= acc_sum;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_out
        assign bus.t[i*N +: N]       = t_reg[i];
        assign bus.current[i*N +: N] = current_reg[i];
    end

    assign bus.total_current = total_q;

endmodule

// File: tb/tb_neurotransmitter_channel_bank.sv
// tb_neurotransmitter_channel_bank
// Self-checking bench for neurotransmitter_channel_bank (N=32, Q=16,
// CHANNELS=4). A table of sweep vectors with hand-computed expectations is
// applied in order (concentrations carry over between sweeps); expectations
// are queued when a sweep is launched and compared when done pulses.
// Hand-written sequences cover reset mid-sweep, apply while busy and a
// back-to-back restart from the done cycle. The overflow vector expects
// saturated or wrapped results depending on NEUROTRANSMITTER_SATURATE_EN.
module tb_neurotransmitter_channel_bank;

    localparam int N   = 32;
    localparam int Q   = 16;
    localparam int CH  = 4;
    localparam int LAT = 3 * CH + 1;

    typedef logic [CH-1:0][N-1:0] lane_t;

    typedef struct {
        string         name;
        logic [CH-1:0] en;
        logic [N-1:0]  voltage;
        logic [N-1:0]  threshold;
        lane_t         tmax, clr, gmax, erev;
        lane_t         exp_t, exp_cur;
        logic [N-1:0]  exp_total;
    } vec_t;

    typedef struct {
        string        name;
        lane_t        t;
        lane_t        cur;
        logic [N-1:0] total;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n;

    int      checks = 0;
    int      errors = 0;
    expect_t sb[$];
    vec_t    vecs[10];

    always #5 clk = ~clk;

    neurotransmitter_channel_bank_if #(.N(N), .CHANNELS(CH)) bus ();

    neurotransmitter_channel_bank #(.N(N), .Q(Q), .CHANNELS(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic lane_t all4(input logic [N-1:0] x);
        return {x, x, x, x};
    endfunction

    function automatic vec_t mk(input string name, input logic [CH-1:0] en,
                                input logic [N-1:0] v, input logic [N-1:0] th,
                                input lane_t tmax, input lane_t clr,
                                input lane_t gmax, input lane_t erev,
                                input lane_t et, input lane_t ec,
                                input logic [N-1:0] tot);
        vec_t r;
        r.name = name; r.en = en; r.voltage = v; r.threshold = th;
        r.tmax = tmax; r.clr = clr; r.gmax = gmax; r.erev = erev;
        r.exp_t = et; r.exp_cur = ec; r.exp_total = tot;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadInputs(input vec_t v);
        bus.voltage                  = v.voltage;
        bus.threshold                = v.threshold;
        bus.channel_en               = v.en;
        bus.tmax                     = v.tmax;
        bus.clear_constant           = v.clr;
        bus.max_synaptic_conductance = v.gmax;
        bus.reversal_potential       = v.erev;
    endtask

    task automatic pushExpect(input vec_t v);
        expect_t e;
        e.name  = v.name;
        e.t     = v.exp_t;
        e.cur   = v.exp_cur;
        e.total = v.exp_total;
        sb.push_back(e);
    endtask

    // Leaves the bench #1 after the edge that sampled apply (sweep cycle 1).
    task automatic applyStimulus(input vec_t v, input bit expect_result);
        loadInputs(v);
        bus.apply = 1'b1;
        if (expect_result) pushExpect(v);
        tick();
        bus.apply = 1'b0;
        check({v.name, "_busy_start"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic waitDone(input string name, input int start, output int cycles);
        cycles = start;
        while (bus.done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        check({name, "_latency"}, 32'(cycles), 32'(LAT));
        check({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: done with no expected result queued");
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < CH; i++) begin
                check($sformatf("%s_t%0d", e.name, i), bus.t[i*N +: N], e.t[i]);
                check($sformatf("%s_cur%0d", e.name, i), bus.current[i*N +: N], e.cur[i]);
            end
            check({e.name, "_total"}, bus.total_current, e.total);
        end
    endtask

    task automatic checkAllZero(input string name);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_done"}, 32'(bus.done), 32'd0);
        check({name, "_total"}, bus.total_current, 32'd0);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s_t%0d", name, i), bus.t[i*N +: N], 32'd0);
            check($sformatf("%s_cur%0d", name, i), bus.current[i*N +: N], 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int    cycles;
        int    spurious;
        lane_t ov_cur;
        logic [N-1:0] ov_total;

`ifdef NEUROTRANSMITTER_SATURATE_EN
        ov_cur   = all4(32'h7FFF_FFFF);
        ov_total = 32'h7FFF_FFFF;
`else
        ov_cur   = all4(32'hE900_0000);
        ov_total = 32'hA400_0000;
`endif
        // Lane literals are written {ch3, ch2, ch1, ch0}.
        vecs[0] = mk("release", 4'hF, 32'h001E_0000, 32'h0,
                     all4(32'h0001_0000), all4(32'h0000_8000), all4(32'h0002_0000), all4(32'h0),
                     all4(32'h0001_0000), all4(32'h003C_0000), 32'h00F0_0000);
        vecs[1] = mk("decay", 4'hF, 32'hFFBF_0000, 32'h0,
                     all4(32'h0001_0000), all4(32'h0000_8000), all4(32'h0001_0000), all4(32'h0),
                     all4(32'h0000_8000), all4(32'hFFDF_8000), 32'hFF7E_0000);
        vecs[2] = mk("mask0101", 4'b0101, 32'h001E_0000, 32'h0,
                     all4(32'h0001_0000), all4(32'h0000_8000), all4(32'h0002_0000), all4(32'h0),
                     {32'h0000_8000, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000},
                     {32'h0, 32'h003C_0000, 32'h0, 32'h003C_0000}, 32'h0078_0000);
        vecs[3] = mk("per_channel", 4'hF, 32'h000A_0000, 32'h0005_0000,
                     {32'h0001_0000, 32'h0000_C000, 32'h0000_8000, 32'h0000_4000},
                     all4(32'h0000_8000), all4(32'h0004_0000),
                     {32'h000A_0000, 32'hFFF6_0000, 32'h0002_0000, 32'h0},
                     {32'h0001_0000, 32'h0000_C000, 32'h0000_8000, 32'h0000_4000},
                     {32'h0, 32'h003C_0000, 32'h0010_0000, 32'h000A_0000}, 32'h0056_0000);
        vecs[4] = mk("decay_clamp", 4'hF, 32'h0, 32'h0005_0000,
                     all4(32'h0001_0000),
                     {32'h0002_0000, 32'h0001_0000, 32'h0000_4000, 32'h0000_8000},
                     all4(32'h0004_0000),
                     {32'h000A_0000, 32'hFFF6_0000, 32'h0002_0000, 32'h0},
                     {32'h0, 32'h0, 32'h0000_6000, 32'h0000_2000},
                     {32'h0, 32'h0, 32'hFFFD_0000, 32'h0}, 32'hFFFD_0000);
        vecs[5] = mk("equal_threshold", 4'hF, 32'h0005_0000, 32'h0005_0000,
                     all4(32'h0001_0000), all4(32'h0000_8000), all4(32'h0001_0000), all4(32'h0),
                     all4(32'h0001_0000), all4(32'h0005_0000), 32'h0014_0000);
        vecs[6] = mk("signed_threshold", 4'hF, 32'h0001_0000, 32'hFFFE_0000,
                     all4(32'h0000_8000), all4(32'h0000_8000), all4(32'h0002_0000), all4(32'hFFFF_0000),
                     all4(32'h0000_8000), all4(32'h0002_0000), 32'h0008_0000);
        vecs[7] = mk("floor", 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     all4(32'h0001_0000), all4(32'h0000_8000), all4(32'h0000_0001), all4(32'h0),
                     all4(32'h0001_0000), all4(32'hFFFF_FFFF), 32'hFFFF_FFFC);
        vecs[8] = mk("all_disabled", 4'h0, 32'h001E_0000, 32'h0,
                     all4(32'h0000_4000), all4(32'h0000_8000), all4(32'h0002_0000), all4(32'h0),
                     all4(32'h0001_0000), all4(32'h0), 32'h0);
        vecs[9] = mk("overflow", 4'hF, 32'h7530_0000, 32'h0,
                     all4(32'h0001_0000), all4(32'h0000_8000), all4(32'h7530_0000), all4(32'h0),
                     all4(32'h0001_0000), ov_cur, ov_total);

        // Reset state
        bus.apply = 1'b0;
        loadInputs(vecs[0]);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Reset mid-sweep: channel 0 has already written t/current by cycle 5.
        applyStimulus(vecs[0], 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_mid_sweep");
        @(negedge clk) rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 1'b1);
            waitDone(vecs[i].name, 1, cycles);
            checkOutput();
            tick();
        end

        // apply pulsed mid-sweep with different operands: ignored, and the
        // changed inputs stay on the bus until done.
        applyStimulus(vecs[0], 1'b1);
        repeat (4) tick();
        loadInputs(vecs[1]);
        bus.apply = 1'b1;
        tick();
        bus.apply = 1'b0;
        waitDone("ignored_apply", 6, cycles);
        checkOutput();

        // Back-to-back restart from the done cycle.
        loadInputs(vecs[5]);
        bus.apply = 1'b1;
        pushExpect(vecs[5]);
        tick();
        bus.apply = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        waitDone("back_to_back", 1, cycles);
        checkOutput();

        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done === 1'b1) spurious++;
        end
        check("no_spurious_done", 32'(spurious), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
